// File: rtl/cnn_pkg.sv
// Shared constants and types for the 4x4 CNN frame sequencer.
// Q4.4 cell words, raster-ordered cells, sequencer state encoding.
package cnn_pkg;
  localparam int WIDTH = 9;
  localparam int CELLS = 16;

  localparam logic [WIDTH-1:0] ONE     = 9'h010;
  localparam logic [WIDTH-1:0] NEG_ONE = 9'h1F0;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // LSB position of cell k in a flat CELLS*w vector.
  function automatic int cell_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/cnn_frame_buffer.sv
// 16-entry input frame register file: indexed write, zero-fill above the
// written index, and a parallel view of the contents as they will be after this edge.
module cnn_frame_buffer #(
  parameter int WIDTH = 9,
  parameter int CELLS = 16,
  parameter int IDXW  = $clog2(CELLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr,
  input  logic [IDXW-1:0]        i_idx,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_zfill,
  output logic [CELLS*WIDTH-1:0] o_next_flat
);
  import cnn_pkg::*;

  for (genvar g = 0; g < CELLS; g++) begin : g_cell
    logic [WIDTH-1:0] r_cell;
    logic [WIDTH-1:0] w_nxt;

    // A short frame clears every cell past the final written index.
    always_comb begin
      w_nxt = r_cell;
      if (i_wr) begin
        if (i_idx == IDXW'(g))                  w_nxt = i_data;
        else if (i_zfill && (IDXW'(g) > i_idx)) w_nxt = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cell <= '0;
      else        r_cell <= w_nxt;
    end

    assign o_next_flat[cell_lsb(g, WIDTH) +: WIDTH] = w_nxt;
  end
endmodule

// File: rtl/cnn_frame_sequencer.sv
// Serial-in / serial-out frame sequencer around the 4x4 CNN array.
// Define CNN_BINARIZE_EN to threshold captured outputs to +/-1.0.
module cnn_frame_sequencer #(
  parameter int WIDTH         = 9,
  parameter int CELLS         = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  output logic [CELLS*WIDTH-1:0] u_flat,
  input  logic [CELLS*WIDTH-1:0] y_flat,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   frame_err
);
  import cnn_pkg::*;

  localparam int IDXW = $clog2(CELLS);
  localparam int CNTW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CELLS - 1);

  state_e                       r_state, w_state_nxt;
  logic [IDXW-1:0]              r_idx, r_oidx;
  logic [CNTW-1:0]              r_cnt;
  logic [CELLS*WIDTH-1:0]       r_u, w_commit;
  logic [CELLS-1:0][WIDTH-1:0]  r_snap, w_cap;
  logic                         r_err;
  logic w_in_xfer, w_out_xfer, w_frame_end, w_settle_done, w_drain_done;

  assign w_in_xfer     = s_valid & s_ready;
  assign w_frame_end   = w_in_xfer & (s_last | (r_idx == LAST_IDX));
  assign w_settle_done = (r_state == SETTLE) && (r_cnt == '0);
  assign w_out_xfer    = m_valid & m_ready;
  assign w_drain_done  = w_out_xfer & (r_oidx == LAST_IDX);

  cnn_frame_buffer #(.WIDTH(WIDTH), .CELLS(CELLS), .IDXW(IDXW)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr        (w_in_xfer),
    .i_idx       (r_idx),
    .i_data      (s_data),
    .i_zfill     (s_last),
    .o_next_flat (w_commit)
  );

  always_comb begin
    w_cap = '0;
    for (int k = 0; k < CELLS; k++) begin
`ifdef CNN_BINARIZE_EN
      w_cap[k] = y_flat[cell_lsb(k, WIDTH) + WIDTH - 1] ? WIDTH'(NEG_ONE) : WIDTH'(ONE);
`else
      w_cap[k] = y_flat[cell_lsb(k, WIDTH) +: WIDTH];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_frame_end)   w_state_nxt = SETTLE;
      SETTLE:  if (w_settle_done) w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_done)  w_state_nxt = LOAD;
      default:                    w_state_nxt = LOAD;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    case (r_state)
      LOAD:   s_ready = 1'b1;
      SETTLE: busy    = 1'b1;
      DRAIN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = (r_oidx == LAST_IDX);
        m_data  = r_snap[r_oidx];
      end
      default: ;
    endcase
  end

  // Framing error: s_last and the final index must coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_oidx <= '0;
      r_cnt  <= '0;
      r_u    <= '0;
      r_snap <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_in_xfer)
        r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
      if (w_in_xfer && (s_last ^ (r_idx == LAST_IDX)))
        r_err <= 1'b1;
      if (w_frame_end) begin
        r_u   <= w_commit;
        r_cnt <= CNTW'(SETTLE_CYCLES - 1);
      end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_settle_done)
        r_snap <= w_cap;
      if (w_out_xfer)
        r_oidx <= w_drain_done ? '0 : r_oidx + 1'b1;
    end
  end

  assign u_flat    = r_u;
  assign frame_err = r_err;
endmodule
